// File: rtl/hrdata_scoreboard_if.sv
// ============================================================================
// Module  : hrdata_scoreboard_if
// Brief   : Bundles the expected/actual HRDATA streams, control and status of
//           the read-data scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface hrdata_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
);
    logic                      exp_valid;
    logic [DATA_W-1:0]         exp_data;
    logic                      act_valid;
    logic [DATA_W-1:0]         act_data;
    logic                      clear_stats;
    logic                      error_pulse;
    logic                      error_sticky;
    logic [CNT_W-1:0]          match_count;
    logic [CNT_W-1:0]          mismatch_count;
    logic                      overflow;
    logic                      underflow;
    logic [DATA_W-1:0]         first_exp;
    logic [DATA_W-1:0]         first_act;
    logic [$clog2(DEPTH):0]    level;
    logic                      empty;

    modport master (
        output exp_valid, exp_data, act_valid, act_data, clear_stats,
        input  error_pulse, error_sticky, match_count, mismatch_count,
               overflow, underflow, first_exp, first_act, level, empty
    );

    modport slave (
        input  exp_valid, exp_data, act_valid, act_data, clear_stats,
        output error_pulse, error_sticky, match_count, mismatch_count,
               overflow, underflow, first_exp, first_act, level, empty
    );
endinterface

`default_nettype wire

// File: rtl/hrdata_scoreboard.sv
// ============================================================================
// Module  : hrdata_scoreboard
// Brief   : In-order HRDATA scoreboard: queues golden words, compares each DUV
//           word against the queue head with 4-state inequality, keeps stats.
//           Optional macro HRDATA_SB_DISPLAY_EN enables simulation messages.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hrdata_scoreboard #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    hrdata_scoreboard_if.slave   sb
);
    localparam int               c_ADDR_W  = $clog2(DEPTH);
    localparam int               c_LEVEL_W = c_ADDR_W + 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0]  r_wr_ptr;
    logic [c_ADDR_W-1:0]  r_rd_ptr;
    logic [c_LEVEL_W-1:0] r_level;

    logic                 r_error_pulse;
    logic                 r_error_sticky;
    logic [CNT_W-1:0]     r_match_count;
    logic [CNT_W-1:0]     r_mismatch_count;
    logic                 r_overflow;
    logic                 r_underflow;
    logic [DATA_W-1:0]    r_first_exp;
    logic [DATA_W-1:0]    r_first_act;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_ovf;
    logic                 w_unf;
    logic [DATA_W-1:0]    w_head;
    logic                 w_mis;
    logic                 w_hit;
    logic [CNT_W-1:0]     w_match_base;
    logic [CNT_W-1:0]     w_mis_base;
    logic                 w_sticky_base;

    assign w_full  = (r_level == c_LEVEL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = sb.act_valid && !w_empty;
    // A word arriving while full is kept only if a pop frees the slot this cycle.
    assign w_push  = sb.exp_valid && (!w_full || w_pop);
    assign w_ovf   = sb.exp_valid && w_full && !w_pop;
    assign w_unf   = sb.act_valid && w_empty;
    assign w_head  = r_mem[r_rd_ptr];
    assign w_mis   = w_pop && (w_head !== sb.act_data);
    assign w_hit   = w_pop && !w_mis;

    // Clear is applied first, so an event retiring alongside it is still recorded.
    assign w_match_base  = sb.clear_stats ? '0   : r_match_count;
    assign w_mis_base    = sb.clear_stats ? '0   : r_mismatch_count;
    assign w_sticky_base = sb.clear_stats ? 1'b0 : r_error_sticky;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sb.exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_level          <= '0;
            r_error_pulse    <= 1'b0;
            r_error_sticky   <= 1'b0;
            r_match_count    <= '0;
            r_mismatch_count <= '0;
            r_overflow       <= 1'b0;
            r_underflow      <= 1'b0;
            r_first_exp      <= '0;
            r_first_act      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LEVEL_W'(1);
                2'b01:   r_level <= r_level - c_LEVEL_W'(1);
                default: r_level <= r_level;
            endcase

            r_error_pulse  <= w_mis;
            r_error_sticky <= w_sticky_base | w_mis;

            r_match_count <= (w_hit && (w_match_base != c_CNT_MAX))
                             ? w_match_base + CNT_W'(1) : w_match_base;
            r_mismatch_count <= (w_mis && (w_mis_base != c_CNT_MAX))
                                ? w_mis_base + CNT_W'(1) : w_mis_base;

            r_overflow  <= (sb.clear_stats ? 1'b0 : r_overflow)  | w_ovf;
            r_underflow <= (sb.clear_stats ? 1'b0 : r_underflow) | w_unf;

            if (w_mis && !w_sticky_base) begin
                r_first_exp <= w_head;
                r_first_act <= sb.act_data;
            end else if (sb.clear_stats) begin
                r_first_exp <= '0;
                r_first_act <= '0;
            end
        end
    end

`ifdef HRDATA_SB_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_mis) begin
                $display("%0t hrdata_scoreboard: data differs exp=%h act=%h",
                         $time, w_head, sb.act_data);
            end
            if (w_ovf) begin
                $display("%0t hrdata_scoreboard: overflow", $time);
            end
            if (w_unf) begin
                $display("%0t hrdata_scoreboard: underflow", $time);
            end
        end
    end
`else
    // Quiet build: behaviour is identical, only the messages are absent.
`endif

    assign sb.error_pulse    = r_error_pulse;
    assign sb.error_sticky   = r_error_sticky;
    assign sb.match_count    = r_match_count;
    assign sb.mismatch_count = r_mismatch_count;
    assign sb.overflow       = r_overflow;
    assign sb.underflow      = r_underflow;
    assign sb.first_exp      = r_first_exp;
    assign sb.first_act      = r_first_act;
    assign sb.level          = r_level;
    assign sb.empty          = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_hrdata_scoreboard.sv
// ============================================================================
// Module  : tb_hrdata_scoreboard
// Brief   : Directed scenarios plus random traffic against a queue-based model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hrdata_scoreboard;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hrdata_scoreboard_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) sb_if ();

    hrdata_scoreboard #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] m_q[$];
    int                m_match;
    int                m_mis;
    bit                m_sticky;
    bit                m_pulse;
    bit                m_ovf;
    bit                m_unf;
    logic [DATA_W-1:0] m_fe;
    logic [DATA_W-1:0] m_fa;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("error_pulse",    64'(sb_if.error_pulse),    64'(m_pulse));
        check_eq("error_sticky",   64'(sb_if.error_sticky),   64'(m_sticky));
        check_eq("match_count",    64'(sb_if.match_count),    64'(m_match));
        check_eq("mismatch_count", 64'(sb_if.mismatch_count), 64'(m_mis));
        check_eq("overflow",       64'(sb_if.overflow),       64'(m_ovf));
        check_eq("underflow",      64'(sb_if.underflow),      64'(m_unf));
        check_eq("first_exp",      64'(sb_if.first_exp),      64'(m_fe));
        check_eq("first_act",      64'(sb_if.first_act),      64'(m_fa));
        check_eq("level",          64'(sb_if.level),          64'(m_q.size()));
        check_eq("empty",          64'(sb_if.empty),          64'(m_q.size() == 0));
    endtask

    task automatic model_clear_stats();
        m_match  = 0;
        m_mis    = 0;
        m_sticky = 0;
        m_ovf    = 0;
        m_unf    = 0;
        m_fe     = '0;
        m_fa     = '0;
    endtask

    // One clock: drive inputs, apply the scoreboard rules to the model, check.
    task automatic step(input bit ev, input logic [DATA_W-1:0] ed,
                        input bit av, input logic [DATA_W-1:0] ad, input bit clr);
        bit                was_full;
        bit                was_empty;
        bit                pop;
        bit                mis;
        bit                hit;
        logic [DATA_W-1:0] head;
        sb_if.exp_valid   = ev;
        sb_if.exp_data    = ed;
        sb_if.act_valid   = av;
        sb_if.act_data    = ad;
        sb_if.clear_stats = clr;
        @(posedge clk);
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        pop = av && !was_empty;
        mis = 1'b0;
        hit = 1'b0;
        head = '0;
        if (pop) begin
            head = m_q.pop_front();
            mis  = (head !== ad);
            hit  = !mis;
        end
        if (clr) model_clear_stats();
        if (ev) begin
            if (!was_full || pop) m_q.push_back(ed);
            else                  m_ovf = 1;
        end
        if (av && was_empty) m_unf = 1;
        if (hit && m_match < CMAX) m_match++;
        if (mis) begin
            if (!m_sticky) begin
                m_fe = head;
                m_fa = ad;
            end
            if (m_mis < CMAX) m_mis++;
            m_sticky = 1;
        end
        m_pulse = mis;
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Reset is applied with busy inputs to show it overrides everything.
    task automatic do_reset();
        reset             = 1'b1;
        sb_if.exp_valid   = 1'b1;
        sb_if.exp_data    = 32'hFFFF_0000;
        sb_if.act_valid   = 1'b1;
        sb_if.act_data    = 32'h1234_0000;
        sb_if.clear_stats = 1'b1;
        @(posedge clk);
        m_q.delete();
        model_clear_stats();
        m_pulse = 0;
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        sb_if.exp_valid   = 1'b0;
        sb_if.exp_data    = '0;
        sb_if.act_valid   = 1'b0;
        sb_if.act_data    = '0;
        sb_if.clear_stats = 1'b0;
        @(posedge clk);
        do_reset();

        // In-order matches
        step(1, 32'hA5A5A5A5, 0, '0, 0);
        step(1, 32'h12345678, 0, '0, 0);
        step(0, '0, 1, 32'hA5A5A5A5, 0);
        step(0, '0, 1, 32'h12345678, 0);
        idle();

        // Mismatch capture, second mismatch must not move the capture
        do_reset();
        step(1, 32'hDEADBEEF, 0, '0, 0);
        step(0, '0, 1, 32'hDEADBEEE, 0);
        step(1, 32'h00000001, 0, '0, 0);
        step(0, '0, 1, 32'h00000002, 0);
        idle();

        // X in the actual word
        do_reset();
        step(1, 32'h00000000, 0, '0, 0);
        step(0, '0, 1, 32'h0000000x, 0);
        idle();

        // Fill, overflow, then push+pop while full
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 32'h100 + 32'(i), 0, '0, 0);
        step(1, 32'h200, 1, 32'h100, 0);
        for (int i = 1; i < 8; i++) step(0, '0, 1, 32'h100 + 32'(i), 0);
        step(0, '0, 1, 32'h200, 0);

        // Underflow with same-cycle push
        do_reset();
        step(1, 32'hCAFE0001, 1, 32'hCAFE0001, 0);
        idle();

        // Saturation, then clear together with a retiring mismatch
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, 32'(i * 7), 0, '0, 0);
            step(0, '0, 1, 32'(i * 7), 0);
        end
        step(1, 32'h55, 0, '0, 0);
        step(1, 32'h66, 0, '0, 0);
        step(0, '0, 1, 32'h56, 1);
        idle();

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit                ev;
            bit                av;
            bit                clr;
            logic [DATA_W-1:0] ed;
            logic [DATA_W-1:0] ad;
            ev  = ($urandom_range(0, 99) < 55);
            av  = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 29) == 0);
            ed  = $urandom;
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0) ad = m_q[0];
            else                                            ad = $urandom;
            if ($urandom_range(0, 149) == 0) do_reset();
            else                             step(ev, ed, av, ad, clr);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
